// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings, widths and tag type for the SRAM port arbiter slice.
package sram_port_arbiter_pkg;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int WEN_W        = 4;
  localparam int READ_LAT_MAX = 4;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // One in-flight read: valid marks a read slot, owner selects the return port.
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/sram_port_arbiter_tag_pipe.sv
// READ_LAT-deep {valid, owner} shift register that tracks reads in flight
// so each SRAM return can be steered to the requester that issued it.
module sram_tag_pipe
  import sram_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stages [DEPTH];

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and the MEM-stage data
// path. Data wins by default; a streak counter lets a waiting fetch through
// after STARVE_LIMIT consecutive data grants. READ_LAT must be 1..READ_LAT_MAX.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [WEN_W-1:0]  data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [WEN_W-1:0]  sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              stallreq
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  logic [STREAK_W-1:0] streak;
  logic                inst_pick;
  tag_t                tag_in;
  tag_t                tag_out;

  // Pick the winner; grants are held off while reset is asserted.
  always_comb begin
    inst_pick = inst_req & (~data_req | (streak == STREAK_MAX));
    inst_gnt  = ~rst & inst_pick;
    data_gnt  = ~rst & data_req & ~inst_pick;
    stallreq  = ~rst & ((inst_req & ~inst_gnt) | (data_req & ~data_gnt));
  end

  // Drive the SRAM port from the winner; idle cycles drive all zeros.
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (data_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end
  end

  // Count data grants that bypass a waiting fetch, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (!inst_req || inst_gnt) begin
      streak <= '0;
    end else if (data_gnt && (streak != STREAK_MAX)) begin
      streak <= streak + 1'b1;
    end
  end

  // Build the tag for this cycle: only reads produce a return slot.
  always_comb begin
    tag_in.valid = sram_en & (sram_wen == '0);
    tag_in.owner = data_gnt ? OWNER_DATA : OWNER_INST;
  end

  sram_tag_pipe #(.DEPTH(READ_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Steer returning data to its owner; the idle port reads back zero.
  always_comb begin
    inst_rvalid = ~rst & tag_out.valid & (tag_out.owner == OWNER_INST);
    data_rvalid = ~rst & tag_out.valid & (tag_out.owner == OWNER_DATA);
    inst_rdata  = inst_rvalid ? sram_rdata : '0;
    data_rdata  = data_rvalid ? sram_rdata : '0;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between instruction fetch (read-only) and the MEM-stage data path (load/store with byte write enables).
- Issues at most one SRAM access per cycle. Tags each read so its data is returned to the correct requester after a fixed read latency.
- Raises a stall request to the pipeline stall controller when either requester is waiting.
- Sits between the IF/MEM stages and the SRAM; the MEM stage still does its own byte/halfword extraction.

Parameters:
- READ_LAT, 1, SRAM read latency in cycles from sram_en to sram_rdata valid (legal range 1-4).
- STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits; after that, instruction wins one grant.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  fetch request; held until inst_gnt
- inst_addr  in  32  fetch address (word aligned)
- inst_gnt  out  1  fetch accepted this cycle
- inst_rvalid  out  1  inst_rdata valid this cycle
- inst_rdata  out  32  fetched word
- data_req  in  1  data access request; held with all fields until data_gnt
- data_wen  in  4  byte write enables; 4'b0000 = read
- data_addr  in  32  data address
- data_wdata  in  32  store data, already byte-lane positioned
- data_gnt  out  1  data access accepted this cycle
- data_rvalid  out  1  data_rdata valid this cycle (reads only)
- data_rdata  out  32  raw loaded word
- sram_en  out  1  SRAM enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data
- stallreq  out  1  to stall controller: some request is not granted this cycle

Behaviour:
- Grant decision is combinational from the current req inputs and registered state. A granted access drives sram_en=1 in the same cycle; the sram_* fields are muxed from the winner.
- No request: sram_en=0, sram_wen=0, addr/wdata=0.
- Priority: data wins by default. Instruction wins instead when inst_req=1, data_req=1 and streak==STARVE_LIMIT.
- streak counter (width clog2(STARVE_LIMIT+1)):
  - Increments on a data grant while inst_req=1.
  - Clears on any inst grant, or on any cycle with inst_req=0.
  - Saturates at STARVE_LIMIT.
- Only one requester: it is granted immediately; there are no idle bubbles.
- Tag pipeline: READ_LAT-deep shift register of {valid, owner}.
  - Stage 0 is loaded with valid=1 on any read grant (sram_wen==0); owner = 0 for inst, 1 for data.
  - Writes and idle cycles load valid=0.
- Return path: when the final tag stage is valid, the matching *_rvalid pulses for exactly one cycle and *_rdata = sram_rdata.
  - The non-matching rvalid stays 0.
  - The other rdata output holds 0 (no X propagation).
- Back-to-back reads from either requester are accepted every cycle; returns preserve grant order.
- A write followed by a read to the same address on consecutive cycles returns the new data; the SRAM provides this ordering and the block adds no bypass.
- stallreq = (inst_req & ~inst_gnt) | (data_req & ~data_gnt). This is combinational and never asserted when no request is pending.
- Reset values: gnt=0, rvalid=0, rdata=0, sram_en=0, sram_wen=0, stallreq=0, streak=0, all tag stages invalid.
- Reset mid-operation: in-flight tags are discarded and no rvalid is produced for reads granted before reset.
- A requester deasserting req before grant is a protocol violation; the block does not need to handle it.

Decomposition:
- Shared defines header gets: owner encodings (OWNER_INST=1'b0, OWNER_DATA=1'b1), READ_LAT max (4), and the SRAM port widths (32-bit addr/data, 4-bit wen).
- One sub-module is natural: sram_tag_pipe, a parameterised READ_LAT-deep {valid, owner} shift register with synchronous reset.
- Arbitration and muxing stay in the top.

Test Plan:
- inst_req only, addr 0x0000_0040, READ_LAT=1, SRAM word 0x1234_5678 -> cycle 0: inst_gnt=1, sram_en=1, sram_addr=0x40, stallreq=0; cycle 1: inst_rvalid=1, inst_rdata=0x1234_5678, data_rvalid=0.
- Simultaneous inst_req (0x100) and data read (0x200) -> cycle 0: data_gnt=1, inst_gnt=0, stallreq=1; cycle 1: inst granted; data_rvalid in cycle 1, inst_rvalid in cycle 2.
- inst_req held high with 6 back-to-back data reads, STARVE_LIMIT=4 -> first 4 cycles grant data, cycle 5 grants inst, cycle 6 grants data again; streak=0 after the inst grant.
- Data store wen=4'b0010, wdata=0x0000_AB00 to 0x300, then data read of 0x300 -> sram_wen=4'b0010 in cycle 0 with no data_rvalid; read returns byte lane 1 = 0xAB.
- READ_LAT=3, alternating inst/data reads for 4 cycles -> rvalid pulses in cycles 3-6 with owners in grant order and correct rdata per owner.
- Assert rst for 1 cycle while 2 reads are in flight (READ_LAT=2) -> no rvalid in the following 2 cycles; all outputs 0 during and after reset until a new request arrives.
